// File: rtl/eater_core_p_if.sv
// Host-side bus of the eater_core_p core.
//   prog_we / prog_addr / prog_data : program-load write request from the host
//   prog_ready                      : the write was taken on this cycle
//   out_data / out_valid            : OUT channel, out_valid is a one-clk strobe
// master = host / display side, slave = the core.
interface eater_core_p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    modport master (
        output prog_we, prog_addr, prog_data,
        input  prog_ready, out_data, out_valid
    );

    modport slave (
        input  prog_we, prog_addr, prog_data,
        output prog_ready, out_data, out_valid
    );
endinterface

// File: rtl/eater_core_p.sv
// eater_core_p: parametrised single-bus breadboard-style CPU core.
// A, B, IR, PC, MAR, carry/zero flags, program RAM and a microstep
// sequencer whose instruction length varies per opcode (the step counter
// returns to T0 on the instruction's last microstep).
// Ports:
//   clk, clr          clock and synchronous active-high clear
//   cont_enable       advance one microstep every clock
//   manual_pulse      single-step request when cont_enable is low
//   bus (slave)       host program-load port and OUT channel
//   halted, pc, step  core status
//   cf, zf            ALU flags (updated only by ADD/SUB)
module eater_core_p #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int RAM_DEPTH = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cont_enable,
    input  logic              manual_pulse,
    eater_core_p_if.slave     bus,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        step,
    output logic              cf,
    output logic              zf
);
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

    // Program/data memory. The read is asynchronous: T1 and T3 consume the
    // word addressed by MAR on the same edge they execute, so a registered
    // read would cost an extra microstep per access.
    logic [DATA_W-1:0] ram [RAM_DEPTH];

    logic [DATA_W-1:0] a_reg, b_reg, ir_reg, out_data_reg;
    logic [ADDR_W-1:0] mar_reg, pc_reg;
    step_t             step_reg;
    logic              cf_reg, zf_reg, out_valid_reg, halted_reg;

    logic              adv, host_wr, sta_wr, is_last, is_sub;
    logic [DATA_W-1:0] ram_rd;
    logic [3:0]        ir_op, cur_op;
    logic [ADDR_W-1:0] opnd;
    logic [DATA_W-1:0] opnd_ext;
    step_t             last_step;
    logic [DATA_W:0]   alu_sum;

    assign adv      = ~halted_reg & (cont_enable | manual_pulse);
    // The host only gets the RAM on cycles the core does not advance, so
    // host and STA writes never collide.
    assign host_wr  = bus.prog_we & ~adv;
    // clr must not let a half-finished STA reach memory.
    assign sta_wr   = adv & ~clr & (step_reg == T3) & (ir_op == OP_STA);

    assign ram_rd   = ram[mar_reg];
    assign ir_op    = ir_reg[DATA_W-1 -: 4];
    assign opnd     = ir_reg[ADDR_W-1:0];
    assign opnd_ext = {{(DATA_W-ADDR_W){1'b0}}, opnd};

    // During T1 the instruction is only just being fetched, so its length
    // has to be decoded from the RAM word rather than from IR (this is what
    // lets NOP finish at T1).
    assign cur_op = (step_reg == T1) ? ram_rd[DATA_W-1 -: 4] : ir_op;

    always_comb begin
        last_step = T1;
        case (cur_op)
            OP_LDA, OP_STA:                         last_step = T3;
            OP_ADD, OP_SUB:                         last_step = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ,
            OP_OUT, OP_HLT:                         last_step = T2;
            default:                                last_step = T1;
        endcase
    end

    assign is_last = (step_reg == last_step);

    // SUB is A + ~B + 1, so the carry out doubles as "no borrow".
    assign is_sub  = (ir_op == OP_SUB);
    assign alu_sum = {1'b0, a_reg} + {1'b0, (is_sub ? ~b_reg : b_reg)}
                   + {{DATA_W{1'b0}}, is_sub};

    always_ff @(posedge clk) begin
        if (sta_wr) begin
            ram[mar_reg] <= a_reg;
        end else if (host_wr) begin
            ram[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            a_reg         <= '0;
            b_reg         <= '0;
            ir_reg        <= '0;
            mar_reg       <= '0;
            pc_reg        <= '0;
            step_reg      <= T0;
            cf_reg        <= 1'b0;
            zf_reg        <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (adv) begin
                step_reg <= is_last ? T0 : step_t'(step_reg + 3'd1);
                case (step_reg)
                    T0: mar_reg <= pc_reg;
                    T1: begin
                        ir_reg <= ram_rd;
                        pc_reg <= pc_reg + ADDR_W'(1);
                    end
                    T2: begin
                        case (ir_op)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_reg <= opnd;
                            OP_LDI: a_reg  <= opnd_ext;
                            OP_JMP: pc_reg <= opnd;
                            OP_JC:  if (cf_reg) pc_reg <= opnd;
                            OP_JZ:  if (zf_reg) pc_reg <= opnd;
                            OP_OUT: begin
                                out_data_reg  <= a_reg;
                                out_valid_reg <= 1'b1;
                            end
                            OP_HLT: halted_reg <= 1'b1;
                            default: ;
                        endcase
                    end
                    T3: begin
                        case (ir_op)
                            OP_LDA:         a_reg <= ram_rd;
                            OP_ADD, OP_SUB: b_reg <= ram_rd;
                            default: ;
                        endcase
                    end
                    T4: begin
                        if (ir_op == OP_ADD || ir_op == OP_SUB) begin
                            {cf_reg, a_reg} <= alu_sum;
                            zf_reg          <= (alu_sum[DATA_W-1:0] == '0);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.prog_ready = host_wr;
    assign bus.out_data   = out_data_reg;
    assign bus.out_valid  = out_valid_reg;
    assign halted         = halted_reg;
    assign pc             = pc_reg;
    assign step           = step_reg;
    assign cf             = cf_reg;
    assign zf             = zf_reg;
endmodule

// File: tb/tb_eater_core_p.sv
// Testbench for eater_core_p: directed programs with hand-computed results
// plus randomized programs / host traffic, all compared every cycle against
// an instruction-level model.
module tb_eater_core_p;
    logic       clk = 1'b0;
    logic       clr, cont_enable, manual_pulse;
    logic       halted, cf, zf;
    logic [3:0] pc;
    logic [2:0] step;

    eater_core_p_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    eater_core_p #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .clr          (clr),
        .cont_enable  (cont_enable),
        .manual_pulse (manual_pulse),
        .bus          (bus),
        .halted       (halted),
        .pc           (pc),
        .step         (step),
        .cf           (cf),
        .zf           (zf)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc_cnt = 0;
    int n_out   = 0;
    int out_cyc = 0;
    int halt_cyc = 0;
    bit chk_en  = 1'b0;
    logic [7:0] img [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc_cnt);
    endtask

    // ---------------- instruction-level reference model ----------------
    // k counts microsteps done in the current instruction; an instruction
    // takes its opcode's length in steps, fetches at its 2nd step and
    // applies its whole result on its final step.
    logic [7:0] ram_m [16];
    logic [7:0] m_a = 0, m_b = 0, m_ir = 0, m_od = 0;
    logic [3:0] m_pc = 0;
    logic       m_cf = 0, m_zf = 0, m_ov = 0, m_halt = 0;
    int         m_k = 0;

    function automatic int ilen(input logic [3:0] opc);
        case (opc)
            4'd1, 4'd4: return 4;
            4'd2, 4'd3: return 5;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd14, 4'd15: return 3;
            default: return 2;
        endcase
    endfunction

    always @(posedge clk) begin
        logic       adv_m;
        logic [8:0] t;
        logic [3:0] opc, opd;
        cyc_cnt++;
        adv_m = !m_halt && (cont_enable || manual_pulse);
        if (bus.prog_we && !adv_m) ram_m[bus.prog_addr] = bus.prog_data;
        if (clr) begin
            m_a = 0; m_b = 0; m_ir = 0; m_od = 0; m_pc = 0;
            m_cf = 0; m_zf = 0; m_ov = 0; m_halt = 0; m_k = 0;
        end else begin
            m_ov = 0;
            if (adv_m) begin
                m_k++;
                if (m_k == 2) begin
                    m_ir = ram_m[m_pc];
                    m_pc = m_pc + 4'd1;
                end
                opc = m_ir[7:4];
                opd = m_ir[3:0];
                if (m_k == 4 && (opc == 2 || opc == 3)) m_b = ram_m[opd];
                if (m_k >= 2 && m_k == ilen(opc)) begin
                    case (opc)
                        4'd1: m_a = ram_m[opd];
                        4'd2, 4'd3: begin
                            if (opc == 2) t = 9'(m_a) + 9'(m_b);
                            else          t = 9'(m_a) + 9'(8'(~m_b)) + 9'd1;
                            m_a  = t[7:0];
                            m_cf = t[8];
                            m_zf = (t[7:0] == 0);
                        end
                        4'd4: ram_m[opd] = m_a;
                        4'd5: m_a = {4'd0, opd};
                        4'd6: m_pc = opd;
                        4'd7: if (m_cf) m_pc = opd;
                        4'd8: if (m_zf) m_pc = opd;
                        4'd14: begin m_od = m_a; m_ov = 1; end
                        4'd15: m_halt = 1;
                        default: ;
                    endcase
                    m_k = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_pc", pc, m_pc);
            chk("cyc_step", step, m_k);
            chk("cyc_cf", cf, m_cf);
            chk("cyc_zf", zf, m_zf);
            chk("cyc_halted", halted, m_halt);
            chk("cyc_out_data", bus.out_data, m_od);
            chk("cyc_out_valid", bus.out_valid, m_ov);
            chk("cyc_prog_ready", bus.prog_ready,
                bus.prog_we && !(!m_halt && (cont_enable || manual_pulse)));
            if (bus.out_valid === 1'b1) begin
                n_out++;
                out_cyc = cyc_cnt;
                $display("OUT data=0x%02h at edge %0d", bus.out_data, cyc_cnt);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Writes img[lo..hi] through the host port with the core held in clear.
    task automatic fill_range(input int lo, input int hi);
        clr = 1; cont_enable = 0; manual_pulse = 0;
        for (int a = lo; a <= hi; a++) begin
            bus.prog_we = 1; bus.prog_addr = 4'(a); bus.prog_data = img[a];
            tick();
            if (a == lo) chk("clr_halted", halted, 0);
        end
        bus.prog_we = 0;
        $display("LOAD words %0d..%0d", lo, hi);
    endtask

    task automatic run_halt(input string name, input int budget);
        int n = 0;
        clr = 0; cont_enable = 1; manual_pulse = 0;
        while (halted !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_halted"}, halted, 1);
        halt_cyc = cyc_cnt;
        cont_enable = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1; cont_enable = 0; manual_pulse = 0;
        bus.prog_we = 0; bus.prog_addr = 0; bus.prog_data = 0;
        tick();
        chk_en = 1;
        chk("rst_pc", pc, 0);
        chk("rst_step", step, 0);
        chk("rst_cf", cf, 0);
        chk("rst_zf", zf, 0);
        chk("rst_halted", halted, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_valid", bus.out_valid, 0);

        // LDI 10; OUT; HLT. LDI and OUT take 3 steps each, HLT 3 more.
        img = '{default: 8'h00};
        img[0] = 8'h5A; img[1] = 8'hE0; img[2] = 8'hF0;
        fill_range(0, 15);
        n_out = 0;
        run_halt("t1", 40);
        chk("t1_out_count", n_out, 1);
        chk("t1_out_data", bus.out_data, 8'h0A);
        chk("t1_halt_lag", halt_cyc - out_cyc, 3);
        chk("t1_pc", pc, 3);
        cont_enable = 1;
        repeat (5) tick();
        chk("t1_pc_hold", pc, 3);
        chk("t1_step_hold", step, 0);
        cont_enable = 0;
        $display("TEST ldi_out_hlt done");

        // 0xC8 + 0x64 = 0x12C -> A=0x2C, carry set.
        img = '{default: 8'h00};
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
        img[14] = 8'hC8; img[15] = 8'h64;
        fill_range(0, 15);
        run_halt("t2", 60);
        chk("t2_out_data", bus.out_data, 8'h2C);
        chk("t2_cf", cf, 1);
        chk("t2_zf", zf, 0);
        $display("TEST add_overflow done");

        // 5-5 = 0: zf=1, cf=1 (no borrow); JZ 7 taken, HLT at 7 leaves pc=8.
        img = '{default: 8'h00};
        img[0] = 8'h55; img[1] = 8'h3F; img[2] = 8'h87; img[3] = 8'hF0;
        img[7] = 8'hF0; img[15] = 8'h05;
        fill_range(0, 15);
        run_halt("t3a", 60);
        chk("t3a_zf", zf, 1);
        chk("t3a_cf", cf, 1);
        chk("t3a_pc", pc, 8);
        // 5-3 = 2: zf=0, JZ falls through to HLT at 3, pc=4.
        img[15] = 8'h03;
        fill_range(15, 15);
        run_halt("t3b", 60);
        chk("t3b_zf", zf, 0);
        chk("t3b_cf", cf, 1);
        chk("t3b_pc", pc, 4);
        $display("TEST sub_jz done");

        // Step mode: one pulse per 10 clocks, host writing to word 12 throughout.
        img = '{default: 8'h00};
        img[0] = 8'h53; img[1] = 8'hF0;
        fill_range(0, 15);
        clr = 0; cont_enable = 0;
        chk("t4_step0", step, 0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 10; i++) begin
                manual_pulse = (i == 9);
                bus.prog_we = 1; bus.prog_addr = 4'd12; bus.prog_data = 8'($urandom_range(0, 255));
                #1;
                chk("t4_prog_ready", bus.prog_ready, (i == 9) ? 0 : 1);
                tick();
                if (i == 8) chk("t4_idle_step", step, p);
                if (i == 9) chk("t4_step_seq", step, (p == 2) ? 0 : p + 1);
            end
        end
        manual_pulse = 0; bus.prog_we = 0;
        $display("TEST step_mode done");

        // STA then LDA round trip through word 15.
        img = '{default: 8'h00};
        img[0] = 8'h59; img[1] = 8'h4F; img[2] = 8'h50; img[3] = 8'h1F;
        img[4] = 8'hE0; img[5] = 8'hF0;
        fill_range(0, 15);
        n_out = 0;
        run_halt("t5", 60);
        chk("t5_out_data", bus.out_data, 8'h09);
        chk("t5_out_count", n_out, 1);
        // JMP 15 with NOP at 15: pc 15 after 3 edges, wraps to 0 after 5.
        img = '{default: 8'h00};
        img[0] = 8'h6F;
        fill_range(0, 15);
        clr = 0; cont_enable = 1;
        repeat (3) tick();
        chk("t5_pc_15", pc, 15);
        repeat (2) tick();
        chk("t5_pc_wrap", pc, 0);
        chk("t5_step_wrap", step, 0);
        cont_enable = 0;
        $display("TEST sta_lda_wrap done");

        // clr at T3 of STA 15 must leave word 15 (0x33) untouched.
        img = '{default: 8'h00};
        img[0] = 8'h57; img[1] = 8'h4F; img[2] = 8'h1F; img[3] = 8'hE0;
        img[4] = 8'hF0; img[15] = 8'h33;
        fill_range(0, 15);
        clr = 0; cont_enable = 1;
        repeat (6) tick();
        chk("t6_at_t3", step, 3);
        clr = 1;
        tick();
        chk("t6_step", step, 0);
        chk("t6_pc", pc, 0);
        chk("t6_cf", cf, 0);
        chk("t6_zf", zf, 0);
        chk("t6_halted", halted, 0);
        chk("t6_out_data", bus.out_data, 0);
        img[0] = 8'h1F; img[1] = 8'hE0; img[2] = 8'hF0;
        fill_range(0, 2);
        run_halt("t6", 60);
        chk("t6_ram_kept", bus.out_data, 8'h33);
        $display("TEST clr_mid_sta done");

        // Randomized programs, run modes, host traffic and occasional clr.
        for (int ep = 0; ep < 25; ep++) begin
            for (int a = 0; a < 16; a++) img[a] = 8'($urandom_range(0, 255));
            fill_range(0, 15);
            for (int c = 0; c < 200; c++) begin
                clr           = ($urandom_range(0, 99) == 0);
                cont_enable   = ($urandom_range(0, 3) != 0);
                manual_pulse  = $urandom_range(0, 1);
                bus.prog_we   = ($urandom_range(0, 7) == 0);
                bus.prog_addr = 4'($urandom_range(0, 15));
                bus.prog_data = 8'($urandom_range(0, 255));
                tick();
            end
            clr = 0; cont_enable = 0; manual_pulse = 0; bus.prog_we = 0;
            $display("RANDOM episode %0d done", ep);
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
